// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, round constants and GF(2^8) helpers for the iterative AES-128 core
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_t;

  // Indexed directly by the 4-bit round counter; entries past round 10 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    r0 = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    r1 = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
    r2 = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
    r3 = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
    return {r0, r1, r2, r3};
  endfunction

  // Byte k of the state is row k%4, column k/4; row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_round_iter.sv
// rtl/aes_round_iter.sv - iterative AES-128 rounds 1..10 with on-the-fly key expansion; optional debug ports under AES_ROUND_DBG_EN
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_ROUND_DBG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_rk
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  aes_fsm_t   fsm_q;
  logic [3:0] round_q;
  aes_state_t state_q;
  aes_state_t key_q;

  aes_state_t sub_bytes;
  aes_state_t shifted;
  aes_state_t mixed;
  aes_state_t round_out;
  aes_state_t rk;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  logic [31:0] temp;
  logic        last_round;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .a (state_q[127 - 8*i -: 8]),
      .y (sub_bytes[127 - 8*i -: 8])
    );
  end

  assign shifted = shift_rows(sub_bytes);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
  end

  assign rot_w3 = rot_word(key_q[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .a (rot_w3[31 - 8*i -: 8]),
      .y (sub_w3[31 - 8*i -: 8])
    );
  end

  assign temp = sub_w3 ^ {RCON[round_q], 24'h000000};

  // Each key word chains off the freshly computed previous word.
  assign rk[127:96] = key_q[127:96] ^ temp;
  assign rk[95:64]  = key_q[95:64]  ^ rk[127:96];
  assign rk[63:32]  = key_q[63:32]  ^ rk[95:64];
  assign rk[31:0]   = key_q[31:0]   ^ rk[63:32];

  assign last_round = (round_q == LAST_ROUND);
  assign round_out  = (last_round ? shifted : mixed) ^ rk;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      round_q   <= 4'd0;
      state_q   <= '0;
      key_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= in_state;
            key_q    <= in_key;
            round_q  <= 4'd1;
            in_ready <= 1'b0;
            fsm_q    <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_out;
          key_q   <= rk;
          if (last_round) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            fsm_q     <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            round_q   <= 4'd0;
            fsm_q     <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_ROUND_DBG_EN
  assign dbg_round = round_q;
  assign dbg_rk    = key_q;
`endif

endmodule

// File: tb/tb_aes_round_iter.sv
// tb/tb_aes_round_iter.sv - self-checking bench for aes_round_iter; debug checks enabled with AES_ROUND_DBG_EN
module tb_aes_round_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_ROUND_DBG_EN
  logic [3:0]   dbg_round;
  logic [127:0] dbg_rk;
`endif

  aes_round_iter #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AES_ROUND_DBG_EN
    ,
    .dbg_round (dbg_round),
    .dbg_rk    (dbg_rk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: S-box derived from GF(2^8) inverse + affine map, textbook round structure.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15 - n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tw;
    logic [127:0] v;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    v = pt ^ key;
    for (int k = 0; k < 16; k++) s[k] = v[127 - 8*k -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c + row] = sb[s[4*((c + row) % 4) + row]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end
        for (int row = 0; row < 4; row++) s[4*c+row] ^= w[4*r + c][31 - 8*row -: 8];
      end
    end
    for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = s[k];
    return v;
  endfunction

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] exp;
    bit           dbg;
  } vec_t;

  vec_t vecs [4];

  // One block: accept, count edges to out_valid, check data, then handshake.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input bit dbg, input string tag);
    int n;
    check({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1'b1));
    in_valid = 1'b1;
    in_state = pt ^ key;
    in_key   = key;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    in_key   = '0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
`ifdef AES_ROUND_DBG_EN
      if (dbg && n == 1) begin
        check({tag, "_dbg_round1"}, 128'(dbg_round), 128'(4'd2));
        check({tag, "_state_r1"}, dut.state_q, 128'h89d810e8855ace682d1843d8cb128fe4);
        check({tag, "_rk_r1"}, dbg_rk, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      end
`endif
    end
    check({tag, "_latency"}, 128'(n), 128'(10));
    check({tag, "_data"}, out_data, exp);
    check({tag, "_in_ready_done"}, 128'(in_ready), 128'(1'b0));
`ifdef AES_ROUND_DBG_EN
    if (dbg) begin
      check({tag, "_rk_final"}, dbg_rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check({tag, "_dbg_round_done"}, 128'(dbg_round), 128'(4'd10));
    end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 128'(out_valid), 128'(1'b0));
    check({tag, "_in_ready_after"}, 128'(in_ready), 128'(1'b1));
    check({tag, "_data_kept"}, out_data, exp);
  endtask

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] exp_b;
    logic [127:0] out_d [2];
    int           out_t [2];
    int           outs;
    int           accepts;
    bit           acc;
    int           n;

    build_sbox();
    vecs[0] = '{C1_PT, C1_KEY, C1_CT, 1'b1};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
    vecs[2] = '{128'h0, 128'h0, ZERO_CT, 1'b0};
    vecs[3] = '{C1_PT, 128'h0, aes_ref(C1_PT, 128'h0), 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; in_key = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_out_data", out_data, 128'h0);
    check("reset_in_ready", 128'(in_ready), 128'(1'b1));

    for (int i = 0; i < 4; i++)
      run_block(vecs[i].pt, vecs[i].key, vecs[i].exp, vecs[i].dbg, $sformatf("vec%0d", i));

    // Backpressure with a competing in_valid that must wait for the handshake.
    in_valid = 1'b1; in_state = C1_PT ^ C1_KEY; in_key = C1_KEY;
    @(posedge clk); #1;
    in_state = '0; in_key = '0;
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check("bp_latency", 128'(n), 128'(10));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_data%0d", k), out_data, C1_CT);
      check($sformatf("bp_hold_valid%0d", k), 128'(out_valid), 128'(1'b1));
      check($sformatf("bp_hold_ready%0d", k), 128'(in_ready), 128'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake_valid", 128'(out_valid), 128'(1'b0));
    check("bp_handshake_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", 128'(in_ready), 128'(1'b0));
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    check("bp_second_latency", 128'(n), 128'(10));
    check("bp_second_data", out_data, ZERO_CT);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_second_done", 128'(in_ready), 128'(1'b1));

    // Reset while the core is at round 5.
    in_valid = 1'b1; in_state = C1_PT ^ C1_KEY; in_key = C1_KEY;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_out_data", out_data, 128'h0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("midrst_no_output", 128'(out_valid), 128'(1'b0));
    run_block(C1_PT, C1_KEY, C1_CT, 1'b0, "after_rst");

    // Back-to-back with in_valid held and out_ready held.
    exp_b = aes_ref(C1_PT, 128'h0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_state = vecs[1].pt ^ vecs[1].key; in_key = vecs[1].key;
    outs = 0; accepts = 0;
    out_t[0] = 0; out_t[1] = 0; out_d[0] = '0; out_d[1] = '0;
    for (int t = 0; t < 40; t++) begin
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) begin
        accepts++;
        if (accepts == 1) begin
          in_state = C1_PT; in_key = 128'h0;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && outs < 2) begin
        out_t[outs] = t; out_d[outs] = out_data; outs++;
      end
    end
    out_ready = 1'b0;
    check("b2b_count", 128'(outs), 128'(2));
    check("b2b_first", out_d[0], vecs[1].exp);
    check("b2b_second", out_d[1], exp_b);
    check("b2b_spacing", 128'(out_t[1] - out_t[0]), 128'(12));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_round_iter.md
Name: aes_round_iter

Overview:
- Iterative AES-128 encryption core. It sits directly downstream of the initial AddRoundKey stage.
- It consumes the post-round-0 state (plaintext XOR cipher key) together with the original cipher key.
- It runs rounds 1..10, one round per clock, and expands round keys on the fly.
- It hands the ciphertext to the output stage over a valid/ready handshake.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; fixed at 10 for AES-128; any other value is unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state/in_key are valid.
- in_ready  out  1  core can accept a block; high only in IDLE.
- in_state  in  128  state after round-0 AddRoundKey; byte 0 = [127:120], column-major per FIPS-197.
- in_key  in  128  round-0 key, i.e. the cipher key; same byte order as in_state.
- out_valid  out  1  out_data holds the ciphertext.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  ciphertext.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; round counter = 0; state and key registers = 0.
  - out_valid = 0, out_data = 0, in_ready = 1 from the following cycle.
  - Reset overrides everything, including mid-round; any in-flight block is discarded with no output.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - Edge with in_valid=1: load state_q <= in_state and key_q <= in_key; round <= 1; go to ROUND.
  - in_valid=0: stay in IDLE.
- ROUND:
  - in_ready = 0.
  - Each edge computes rk = KeyExpand(key_q, rcon[round]), then:
    - state_q <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_q))), rk).
    - key_q <= rk.
    - round <= round + 1.
  - When round == NUM_ROUNDS, MixColumns is bypassed. The result is registered into out_data, out_valid <= 1, and the FSM goes to DONE.
- KeyExpand:
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- DONE:
  - out_valid = 1; out_data is held stable while out_ready = 0.
  - Edge with out_ready=1: out_valid <= 0, FSM goes to IDLE; out_data keeps its last value.
- Timing:
  - Latency: out_valid rises exactly 10 edges after the accepting edge.
  - Minimum block-to-block spacing: 12 cycles (accept, 10 rounds, output handshake).
- Boundary conditions:
  - in_valid while not in IDLE is ignored; in_ready=0 tells the upstream to hold.
  - out_ready while not in DONE has no effect.
  - Round counter is 4 bits and never exceeds NUM_ROUNDS; no wrap.
- Arithmetic:
  - All operations are in GF(2^8) with modulus 0x11b.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0), kept to 8 bits.

Optional Feature:
- Macro: AES_ROUND_DBG_EN.
- Defined:
  - Adds output dbg_round [3:0], equal to the round counter (0 in IDLE, 1..10 in ROUND, 10 in DONE).
  - Adds output dbg_rk [127:0], equal to the current round key key_q.
- Undefined: these ports do not exist, and the functional behaviour is identical.

Decomposition:
- Package aes_pkg holds:
  - the state typedef, a 128-bit logic vector;
  - the FSM state enum {IDLE, ROUND, DONE};
  - the RCON constant array;
  - functions xtime, mix_column (32-bit), shift_rows, rot_word.
- Sub-module aes_sbox: combinational 8-bit S-box lookup.
  - Instantiated 16× for SubBytes and 4× for SubWord.

Test Plan:
- FIPS-197 C.1: in_state=00102030405060708090a0b0c0d0e0f0, in_key=000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_valid exactly 10 cycles after accept; out_data=69c4e0d86a7b0430d8cdb78070b4c55a; then back to IDLE with in_ready=1.
- Same vector with AES_ROUND_DBG_EN -> after round 1: state_q=89d810e8855ace682d1843d8cb128fe4, dbg_rk=d6aa74fdd2af72fadaa678f1d6ab76fe; final dbg_rk=13111d7fe3944a17f307a78b4d2b30c5.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stays stable at 69c4...c55a, in_ready stays 0, and a second in_valid is not accepted until one cycle after the out_ready handshake.
- Reset mid-operation: rst=1 at round 5 -> next cycle IDLE, out_valid=0, in_ready=1; a fresh C.1 block then yields the correct ciphertext.
- Back-to-back: two blocks with in_valid held high (second block is C.1 with key all-zero, in_state=00112233...ff ^ 0) -> both ciphertexts match a reference model, in order, with 12-cycle spacing.
